// File: rtl/frame_wr_pkg.sv
// Shared types and constants for the frame buffer write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_wr_pkg;

    typedef enum logic [1:0] {
        ARB        = 2'd0,
        CLEAR_PEND = 2'd1,
        CLEAR      = 2'd2
    } state_t;

    localparam int FB_ADDR_W            = 19;
    localparam int FB_DATA_W            = 8;
    localparam int FRAME_PIXELS_DEFAULT = 307200;

    localparam logic [FB_DATA_W-1:0] CLEAR_COLOR_DEFAULT = 8'h00;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; grant is zero when no requester is valid.
// Ports: valid (request vector), ptr (search start) -> grant (one-hot), idx (granted index), any (a grant exists).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    // First pass covers indices at or above ptr, second pass wraps to the
    // indices below ptr; the first hit in that order wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[i] && (PTR_W'(i) >= ptr)) begin
                grant[i] = 1'b1;
                idx      = PTR_W'(i);
                any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && valid[i] && (PTR_W'(i) < ptr)) begin
                grant[i] = 1'b1;
                idx      = PTR_W'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_write_arbiter.sv
// Merges NUM_REQ pixel write requesters onto one frame buffer write port, with an optional clear sweep.
// Latency: a granted write shows on wr_* one cycle after its handshake; the sweep writes one pixel per cycle.
// Backpressure: req_ready is a combinational one-hot grant, held at 0 during the sweep and while in reset.
// Ports: Clk, Reset_n; req_valid/req_addr/req_data/req_ready requester side; frame_start, clear_req,
//        clear_busy clear control; wr_addr/wr_data/wr_en frame buffer write port.
// Build option: define FRAME_WRITE_ARBITER_CLEAR_EN to include the clear engine (absent by default).
module frame_write_arbiter
    import frame_wr_pkg::*;
#(
    parameter int                   NUM_REQ      = 4,
    parameter int                   FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter logic [FB_DATA_W-1:0] CLEAR_COLOR  = CLEAR_COLOR_DEFAULT
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FB_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*FB_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           frame_start,
    input  logic                           clear_req,
    output logic                           clear_busy,
    output logic [FB_ADDR_W-1:0]           wr_addr,
    output logic [FB_DATA_W-1:0]           wr_data,
    output logic                           wr_en
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int AW1   = FB_ADDR_W + 1;
    // One extra bit so a limit of exactly 2^FB_ADDR_W still compares correctly.
    localparam logic [AW1-1:0] PIX_LIMIT = AW1'(FRAME_PIXELS);

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     ptr_next;
    logic [NUM_REQ-1:0]   grant;
    logic                 grant_any;
    logic                 serving;
    logic                 xfer;
    logic                 in_range;
    logic [FB_ADDR_W-1:0] sel_addr;
    logic [FB_DATA_W-1:0] sel_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

`ifdef FRAME_WRITE_ARBITER_CLEAR_EN
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FRAME_PIXELS - 1);

    state_t               state_q;
    state_t               state_d;
    logic [FB_ADDR_W-1:0] clr_addr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:        if (clear_req)   state_d = frame_start ? CLEAR : CLEAR_PEND;
            CLEAR_PEND: if (frame_start) state_d = CLEAR;
            CLEAR:      if (clr_addr == LAST_ADDR) state_d = ARB;
            default:    state_d = ARB;
        endcase
    end

    // Parked at 0 outside the sweep so every sweep starts from address 0.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clr_addr <= '0;
        end else if (state_q == CLEAR) begin
            clr_addr <= clr_addr + FB_ADDR_W'(1);
        end else begin
            clr_addr <= '0;
        end
    end

    assign serving    = Reset_n && (state_q != CLEAR);
    assign clear_busy = (state_q != ARB);
`else
    logic unused_clear_in;
    assign unused_clear_in = &{1'b0, clear_req, frame_start, CLEAR_COLOR};

    assign serving    = Reset_n;
    assign clear_busy = 1'b0;
`endif

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*FB_ADDR_W +: FB_ADDR_W];
                sel_data = req_data[i*FB_DATA_W +: FB_DATA_W];
            end
        end
    end

    // Ready is forced low in reset so no handshake can be seen while the
    // write port and pointer are held cleared.
    assign req_ready = serving ? grant : '0;
    assign xfer      = serving && grant_any;
    assign in_range  = ({1'b0, sel_addr} < PIX_LIMIT);
    assign ptr_next  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // Out-of-range requests still complete their handshake and advance the
    // pointer; only the frame buffer write is suppressed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rr_ptr  <= '0;
        end else begin
            wr_en <= 1'b0;
`ifdef FRAME_WRITE_ARBITER_CLEAR_EN
            if (state_q == CLEAR) begin
                wr_en   <= 1'b1;
                wr_addr <= clr_addr;
                wr_data <= CLEAR_COLOR;
            end
`endif
            if (xfer) begin
                wr_en   <= in_range;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                rr_ptr  <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_frame_write_arbiter.sv
module tb_frame_write_arbiter;

    localparam int N = 4;
`ifdef FRAME_WRITE_ARBITER_CLEAR_EN
    localparam int FP = 4096;
`else
    localparam int FP = 307200;
`endif
    localparam logic [7:0] CC = 8'h00;

    localparam int M_ARB  = 0;
    localparam int M_PEND = 1;
    localparam int M_CLR  = 2;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [N-1:0]    req_valid;
    logic [N*19-1:0] req_addr;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            frame_start;
    logic            clear_req;
    logic            clear_busy;
    logic [18:0]     wr_addr;
    logic [7:0]      wr_data;
    logic            wr_en;

    frame_write_arbiter #(
        .NUM_REQ      (N),
        .FRAME_PIXELS (FP)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .frame_start (frame_start),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_en       (wr_en)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
        int          c;
    } wr_t;
    wr_t exp_q[$];

    // Reference model: pending requester transactions and arbiter view.
    bit          cur_v[N];
    logic [18:0] cur_a[N];
    logic [7:0]  cur_d[N];
    bit          refill[N];
    int          gen_pct = 0;
    int          m_mode  = M_ARB;
    int          m_ptr   = 0;
    int          m_clr   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic new_txn(input int i);
        cur_v[i] = 1'b1;
        if ($urandom_range(9) == 0) cur_a[i] = 19'($urandom_range(FP + 40, FP));
        else                        cur_a[i] = 19'($urandom_range(FP - 1, 0));
        cur_d[i] = 8'($urandom);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = cur_v[i];
            req_addr[i*19 +: 19]   = cur_a[i];
            req_data[i*8 +: 8]     = cur_d[i];
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, predict the
    // grant and the resulting write, check the combinational outputs.
    task automatic step(input bit cr, input bit fs);
        logic [N-1:0] exp_rdy;
        int g;
        @(negedge Clk);
        for (int i = 0; i < N; i++)
            if (!cur_v[i] && (refill[i] || $urandom_range(99) < gen_pct)) new_txn(i);
        drive_reqs();
        clear_req   = cr;
        frame_start = fs;
        #2;
        exp_rdy = '0;
        g = -1;
        if (m_mode != M_CLR) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && cur_v[j]) g = j;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("clear_busy", clear_busy, (m_mode != M_ARB));
        if (m_mode == M_CLR) begin
            exp_q.push_back('{a: 19'(m_clr), d: CC, c: cyc + 1});
            m_clr++;
            if (m_clr == FP) m_mode = M_ARB;
        end else begin
            if (g >= 0) begin
                if (cur_a[g] < FP) exp_q.push_back('{a: cur_a[g], d: cur_d[g], c: cyc + 1});
                m_ptr    = (g + 1) % N;
                cur_v[g] = 1'b0;
            end
`ifdef FRAME_WRITE_ARBITER_CLEAR_EN
            if (m_mode == M_ARB && cr) begin
                m_mode = fs ? M_CLR : M_PEND;
                m_clr  = 0;
            end else if (m_mode == M_PEND && fs) begin
                m_mode = M_CLR;
                m_clr  = 0;
            end
`endif
        end
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) refill[i] = 1'b0;
        gen_pct = 0;
        repeat (N + 2) step(1'b0, 1'b0);
    endtask

    // Monitor: every frame buffer write is matched against the scoreboard.
    initial begin
        wr_t e;
        forever begin
            @(negedge Clk);
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_wr_en", wr_en, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", wr_addr, e.a);
                    check("wr_data", wr_data, e.d);
                    check("wr_cycle", cyc, e.c);
                end
            end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                e = exp_q.pop_front();
                check("missing_wr_en", wr_en, 1'b1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n     = 1'b0;
        clear_req   = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            refill[i] = 1'b0;
            new_txn(i);
        end
        drive_reqs();
        #1;
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_clear_busy", clear_busy, 1'b0);
        check("rst_req_ready", req_ready, 0);
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        // All requesters continuously valid: strict rotation 0,1,2,3,0,...
        for (int i = 0; i < N; i++) refill[i] = 1'b1;
        repeat (9) step(1'b0, 1'b0);
        drain();

        // Lone requester 2, fixed transfer.
        cur_v[2] = 1'b1; cur_a[2] = 19'd100; cur_d[2] = 8'h3C;
        repeat (3) step(1'b0, 1'b0);

        // Address boundaries on requester 0.
        cur_v[0] = 1'b1; cur_a[0] = 19'(FP);     cur_d[0] = 8'hA5;
        repeat (2) step(1'b0, 1'b0);
        cur_v[0] = 1'b1; cur_a[0] = 19'(FP - 1); cur_d[0] = 8'h5A;
        repeat (2) step(1'b0, 1'b0);
        cur_v[0] = 1'b1; cur_a[0] = 19'd307200;  cur_d[0] = 8'h77;
        repeat (2) step(1'b0, 1'b0);

        // Random traffic with stray frame_start pulses.
        gen_pct = 55;
        repeat (1500) step(1'b0, ($urandom_range(15) == 0));

        // Clear requested, frame_start ten cycles later, requester 1 always valid.
        gen_pct = 20;
        refill[1] = 1'b1;
        step(1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int k = 0; k < FP + 8 && m_mode != M_ARB; k++)
            step(1'($urandom_range(1)), 1'($urandom_range(1)));
        repeat (20) step(1'b0, 1'b0);

        // Clear started at once, then reset part-way through the sweep.
        step(1'b1, 1'b1);
        for (int k = 0; k < 2100 && m_mode == M_CLR && m_clr < 2000; k++) step(1'b0, 1'b0);
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        check("midrst_wr_en", wr_en, 1'b0);
        check("midrst_clear_busy", clear_busy, 1'b0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_wr_addr", wr_addr, 0);
        m_mode = M_ARB;
        m_ptr  = 0;
        m_clr  = 0;
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;

        gen_pct = 50;
        repeat (200) step(1'b0, ($urandom_range(7) == 0));
        drain();
        repeat (3) @(negedge Clk);
        check("pending_writes", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
